// File: rtl/scf_pkg.sv
// Shared SCF definitions: word layout, opcode/funct constants and the CF classifier
// used by both the tagger and the checker.
package scf_pkg;

  localparam int TAG_LSB = 42;
  localparam int TAG_W   = 22;
  localparam int SEQ_LSB = 32;
  localparam int SEQ_W   = 10;
  localparam int INSTR_W = 32;
  localparam int WORD_W  = 64;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_BLEZ    = 6'd6;
  localparam logic [5:0] OP_BGTZ    = 6'd7;

  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_JALR = 6'd9;

  typedef enum logic {
    ST_UNSEEDED,
    ST_RUN
  } scf_state_e;

  // Must stay bit-identical to the checker's view of control flow.
  function automatic logic scf_is_cf(input logic [INSTR_W-1:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rd;
    logic       is_cf;
    op = instr[31:26];
    fn = instr[5:0];
    rd = instr[15:11];
    case (op)
      OP_J, OP_JAL, OP_BEQ, OP_BNE: is_cf = 1'b1;
      OP_REGIMM:                    is_cf = (rd <= 5'd1);
      OP_BLEZ, OP_BGTZ:             is_cf = (rd == 5'd0);
      OP_SPECIAL:                   is_cf = (fn == FN_JR) || (fn == FN_JALR);
      default:                      is_cf = 1'b0;
    endcase
    return is_cf;
  endfunction

endpackage

// File: rtl/scf_skid_buf.sv
// Generic 2-entry valid/ready buffer: an output register backed by one skid register.
// o_ready depends only on the skid register, so there is no path from i_ready.
module scf_skid_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the data registers are reset too because out_word must read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (r_out_valid && !i_ready) begin
      if (i_valid) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= i_data;
      end
    end else if (r_skid_valid) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= r_skid_data;
      r_skid_valid <= 1'b0;
    end else begin
      r_out_valid <= i_valid;
      if (i_valid) r_out_data <= i_data;
    end
  end

  assign o_ready = !r_skid_valid;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

endmodule

// File: rtl/scf_tagger.sv
// SCF producer: classifies instructions, tags control flow with a running 22-bit LFSR
// and emits {tag, seq, instr} words through a 2-entry output buffer.
module scf_tagger
  import scf_pkg::*;
#(
  parameter bit              AUTO_SEED    = 1'b1,
  parameter logic [TAG_W-1:0] DEFAULT_SEED = 22'h2A5F1,
  parameter int              CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               seed_load,
  input  logic [TAG_W-1:0]   seed_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_word,
  output logic [CNT_W-1:0]   cf_count
);

  localparam logic [TAG_W-1:0] RESET_LFSR  = (DEFAULT_SEED == '0) ? TAG_W'(1) : DEFAULT_SEED;
  localparam scf_state_e       RESET_STATE = AUTO_SEED ? ST_RUN : ST_UNSEEDED;

  scf_state_e        r_state;
  scf_state_e        w_state_next;
  logic              r_armed;
  logic [TAG_W-1:0]  r_lfsr;
  logic [SEQ_W-1:0]  r_seq;
  logic [CNT_W-1:0]  r_cf_count;

  logic              w_buf_ready;
  logic              w_accept;
  logic              w_is_cf;
  logic              w_cf_accept;
  logic [TAG_W-1:0]  w_lfsr_adv;
  logic [TAG_W-1:0]  w_seed_fixed;
  logic [WORD_W-1:0] w_word;

  assign w_is_cf      = scf_is_cf(in_instr);
  assign w_accept     = in_valid && in_ready;
  assign w_cf_accept  = w_accept && w_is_cf;
  assign w_lfsr_adv   = {r_lfsr[TAG_W-2:0], r_lfsr[21] ^ r_lfsr[20]};
  assign w_seed_fixed = (seed_data == '0) ? TAG_W'(1) : seed_data;

  // r_armed keeps in_ready low for the first cycle after reset release.
  assign in_ready = r_armed && (r_state == ST_RUN) && w_buf_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_STATE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_armed <= 1'b1;
    end
  end

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    w_state_next = r_state;
    if ((r_state == ST_UNSEEDED) && seed_load) w_state_next = ST_RUN;
  end

  // A seed load wins over the advance: the accepted word still uses the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr     <= RESET_LFSR;
      r_seq      <= '0;
      r_cf_count <= '0;
    end else begin
      if (seed_load)        r_lfsr <= w_seed_fixed;
      else if (w_cf_accept) r_lfsr <= w_lfsr_adv;
      if (w_accept) r_seq <= r_seq + SEQ_W'(1);
      if (w_cf_accept && (r_cf_count != '1)) r_cf_count <= r_cf_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_word                     = '0;
    w_word[TAG_LSB +: TAG_W]   = w_is_cf ? r_lfsr : '0;
    w_word[SEQ_LSB +: SEQ_W]   = r_seq;
    w_word[INSTR_W-1:0]        = in_instr;
  end

  scf_skid_buf #(
    .W (WORD_W)
  ) u_out_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_accept),
    .o_ready (w_buf_ready),
    .i_data  (w_word),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (out_word)
  );

  assign cf_count = r_cf_count;

endmodule

// File: tb/tb_scf_tagger.sv
// Self-checking bench for scf_tagger: directed steps plus randomized traffic compared
// against a queue-based reference model; a second instance covers AUTO_SEED=0.
module tb_scf_tagger;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        seed_load;
  logic [21:0] seed_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_word;
  logic [15:0] cf_count;

  logic        rst2_n;
  logic        n_in_valid;
  logic        n_in_ready;
  logic [31:0] n_in_instr;
  logic        n_seed_load;
  logic [21:0] n_seed_data;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [63:0] n_out_word;
  logic [3:0]  n_cf_count;

  scf_tagger u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .seed_load (seed_load),
    .seed_data (seed_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .cf_count  (cf_count)
  );

  scf_tagger #(
    .AUTO_SEED (1'b0),
    .CNT_W     (4)
  ) u_dut_ns (
    .clk       (clk),
    .rst_n     (rst2_n),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .in_instr  (n_in_instr),
    .seed_load (n_seed_load),
    .seed_data (n_seed_data),
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .out_word  (n_out_word),
    .cf_count  (n_cf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [21:0] m_lfsr;
  int          m_seq;
  int          m_cf;
  logic [63:0] q[$];
  bit          hold_pend;
  logic [63:0] hold_word;
  bit          chk_rdy;
  bit          last_acc;

  function automatic bit ref_is_cf(input logic [31:0] w);
    int op, fn, rd;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    rd = int'(w[15:11]);
    return (op inside {[2:5]}) || (op == 1 && rd inside {0, 1}) ||
           (op inside {6, 7} && rd == 0) || (op == 0 && fn inside {8, 9});
  endfunction

  function automatic logic [21:0] ref_lfsr_next(input logic [21:0] x);
    int v;
    v = int'(x);
    return 22'(((v << 1) | (((v >> 21) ^ (v >> 20)) & 1)) & 32'h3F_FFFF);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [4:0] rd;
    logic [5:0] fn;
    logic [31:0] r;
    r  = $urandom;
    op = 6'($urandom_range(0, 9));
    rd = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       fn = 6'd8;
      1:       fn = 6'd9;
      2:       fn = 6'd32;
      default: fn = r[5:0];
    endcase
    return {op, r[25:16], rd, r[10:6], fn};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_lfsr    = 22'h2A5F1;
    m_seq     = 0;
    m_cf      = 0;
    hold_pend = 1'b0;
    chk_rdy   = 1'b0;
  endtask

  // One clock of the main instance: observe at the falling edge, update the model,
  // then return 1 ns after the rising edge so the caller can drive the next inputs.
  task automatic step();
    bit cf;
    @(negedge clk);
    if (chk_rdy) chk("in_ready", in_ready, q.size() < 2);
    chk("cf_count", cf_count, m_cf);
    if (hold_pend) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_word", out_word, hold_word);
    end
    hold_pend = out_valid && !out_ready;
    hold_word = out_word;
    if (out_valid && out_ready) begin
      chk("out_expected", q.size() != 0, 1'b1);
      if (q.size() != 0) chk("out_word", out_word, q.pop_front());
    end
    last_acc = in_valid && in_ready;
    cf       = ref_is_cf(in_instr);
    if (last_acc) begin
      q.push_back({cf ? m_lfsr : 22'h0, 10'(m_seq), in_instr});
      m_seq = (m_seq + 1) % 1024;
      if (cf) m_cf++;
    end
    if (seed_load)        m_lfsr = (seed_data == 22'h0) ? 22'h1 : seed_data;
    else if (last_acc && cf) m_lfsr = ref_lfsr_next(m_lfsr);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    seed_load = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    chk("drain_empty", q.size() == 0, 1'b1);
  endtask

  initial begin
    logic [21:0] old_tag;
    logic [21:0] n_lfsr;
    logic [31:0] w;
    logic [63:0] exp_w;
    bit          cf;

    rst_n = 1'b0;  rst2_n = 1'b0;
    in_valid = 1'b0;  in_instr = '0;  seed_load = 1'b0;  seed_data = '0;  out_ready = 1'b1;
    n_in_valid = 1'b0;  n_in_instr = '0;  n_seed_load = 1'b0;  n_seed_data = '0;  n_out_ready = 1'b1;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_word", out_word, 64'h0);
    chk("rst_cf_count", cf_count, 16'h0);
    rst_n = 1'b1;  rst2_n = 1'b1;
    chk("rel_in_ready0", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("rel_in_ready1", in_ready, 1'b1);
    chk_rdy = 1'b1;

    // First CF word carries the default seed, the next one the advanced value.
    in_valid = 1'b1;  in_instr = 32'h1000_0003;
    step();
    chk("lat_valid", out_valid, 1'b1);
    chk("first_tag", out_word[63:42], 22'h2A5F1);
    chk("first_seq", out_word[41:32], 10'd0);
    step();
    chk("second_tag", out_word[63:42], ref_lfsr_next(22'h2A5F1));
    in_instr = 32'h0000_0020;
    step();
    chk("noncf_tag", out_word[63:42], 22'h0);
    in_instr = 32'h1000_0003;
    step();
    chk("after_noncf_tag", out_word[63:42], ref_lfsr_next(ref_lfsr_next(22'h2A5F1)));
    drain();

    // Backpressure: two words buffered, third waits, all drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;  in_instr = 32'h0800_0001;
    step();
    in_instr = 32'h0000_0120;
    step();
    chk("stall_in_ready", in_ready, 1'b0);
    in_instr = 32'h0400_0000;
    step();
    step();
    chk("stall_in_ready2", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_acc) break;
    end
    chk("stall_third_taken", last_acc, 1'b1);
    drain();

    // Zero seed together with a CF accept.
    old_tag   = m_lfsr;
    in_valid  = 1'b1;  in_instr = 32'h1000_0003;
    seed_load = 1'b1;  seed_data = 22'h0;
    step();
    chk("seed_same_cycle_tag", out_word[63:42], old_tag);
    seed_load = 1'b0;
    step();
    chk("seed_zero_tag", out_word[63:42], 22'h1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      out_ready = ($urandom_range(0, 2) != 0);
      seed_load = ($urandom_range(0, 19) == 0);
      seed_data = ($urandom_range(0, 1) == 0) ? 22'h0 : 22'($urandom);
      step();
    end
    drain();

    // Asynchronous reset with two words buffered.
    out_ready = 1'b0;  in_valid = 1'b1;  in_instr = 32'h1400_0000;
    step();
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_word", out_word, 64'h0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_cf_count", cf_count, 16'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    chk("midrst_rel_ready0", in_ready, 1'b0);
    step();
    chk("midrst_rel_ready1", in_ready, 1'b1);
    chk_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_stale", out_valid, 1'b0);
    end
    in_valid = 1'b1;  in_instr = 32'h1000_0003;
    step();
    chk("midrst_fresh_tag", out_word[63:42], 22'h2A5F1);
    chk("midrst_fresh_seq", out_word[41:32], 10'd0);
    drain();

    // AUTO_SEED=0 instance: blocked until seeded, then sequence wrap and count saturation.
    n_in_valid = 1'b1;  n_in_instr = 32'h0800_0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("ns_in_ready_idle", n_in_ready, 1'b0);
      chk("ns_out_valid_idle", n_out_valid, 1'b0);
    end
    n_seed_load = 1'b1;  n_seed_data = 22'h3;
    @(posedge clk);
    #1;
    n_seed_load = 1'b0;
    chk("ns_seed_no_accept", n_out_valid, 1'b0);
    chk("ns_ready_after_seed", n_in_ready, 1'b1);
    n_lfsr = 22'h3;
    for (int k = 0; k < 1100; k++) begin
      cf = (k % 2 == 0);
      w  = cf ? {6'd2, 10'(k), 16'h0} : {6'd0, 10'(k), 10'd0, 6'd32};
      n_in_instr = w;
      exp_w = {cf ? n_lfsr : 22'h0, 10'(k % 1024), w};
      if (cf) n_lfsr = ref_lfsr_next(n_lfsr);
      @(posedge clk);
      #1;
      chk("ns_valid", n_out_valid, 1'b1);
      chk("ns_word", n_out_word, exp_w);
      if (k == 1024) chk("ns_seq_wrap", n_out_word[41:32], 10'd0);
    end
    n_in_valid = 1'b0;
    chk("ns_cf_saturated", n_cf_count, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
